// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave over a dual-port 32-bit memory with independent read and write engines
module axi_mem_responder #(
  parameter int MEM_WORD_BITS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] axi_awaddr,
  input  logic [7:0]  axi_awlen,
  input  logic [2:0]  axi_awsize,
  input  logic [1:0]  axi_awburst,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wlast,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [31:0] axi_araddr,
  input  logic [7:0]  axi_arlen,
  input  logic [2:0]  axi_arsize,
  input  logic [1:0]  axi_arburst,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  output logic        axi_rlast,
  input  logic        axi_rready
);
  localparam int MW = MEM_WORD_BITS;
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  logic [31:0] mem [2**MW];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_araddr[1:0], axi_awaddr[1:0]};
  // Word addresses carry a 33rd byte-address bit so INCR past 4 GiB stays out-of-range
  r_state_t    r_state, r_next;
  logic [32:2] r_addr, r_beat;
  logic [7:0]  r_len, r_cnt;
  logic        r_fixed, r_size_err, r_beat_size_err, ar_hs, r_adv, rd_en;
  logic [1:0]  r_resp, r_beat_resp;
  logic [31:0] rd_q;
  assign axi_arready = r_state == R_IDLE;
  assign axi_rvalid  = r_state == R_BURST;
  assign axi_rlast   = axi_rvalid && r_cnt == r_len;
  assign axi_rresp   = r_resp;
  assign axi_rdata   = r_resp == 2'b00 ? rd_q : 32'd0;
  always_comb begin
    ar_hs = r_state == R_IDLE && axi_arvalid;
    r_adv = r_state == R_BURST && axi_rready && !axi_rlast;
    rd_en = ar_hs || r_adv;
    r_beat = ar_hs ? {1'b0, axi_araddr[31:2]} : r_fixed ? r_addr : r_addr + 31'd1;
    r_beat_size_err = ar_hs ? axi_arsize != 3'b010 : r_size_err;
    r_beat_resp = r_beat_size_err ? 2'b10 : |r_beat[32:MW+2] ? 2'b11 : 2'b00;
    r_next = ar_hs ? R_BURST : (axi_rvalid && axi_rready && axi_rlast) ? R_IDLE : r_state;
  end
  always_ff @(posedge clk) r_state <= rst ? R_IDLE : r_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp <= 2'b00;
      r_cnt  <= 8'd0;
    end else if (rd_en) begin
      r_addr <= r_beat;
      r_resp <= r_beat_resp;
      r_cnt  <= ar_hs ? 8'd0 : r_cnt + 8'd1;
      if (ar_hs) begin
        r_len      <= axi_arlen;
        r_fixed    <= axi_arburst == 2'b00;
        r_size_err <= axi_arsize != 3'b010;
      end
    end
  end
  // Registered read port: a same-cycle write to the same word is seen on the next read
  always_ff @(posedge clk) if (rd_en) rd_q <= mem[r_beat[MW+1:2]];
  w_state_t    w_state, w_next;
  logic [32:2] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic        w_fixed, w_size_err, w_dec, w_slv, aw_hs, w_hs, w_oob, w_at_len, mem_we;
  assign axi_awready = w_state == W_IDLE;
  assign axi_wready  = w_state == W_DATA;
  assign axi_bvalid  = w_state == W_RESP;
  assign axi_bresp   = (w_size_err || w_slv) ? 2'b10 : w_dec ? 2'b11 : 2'b00;
  always_comb begin
    aw_hs    = w_state == W_IDLE && axi_awvalid;
    w_hs     = w_state == W_DATA && axi_wvalid;
    w_oob    = |w_addr[32:MW+2];
    w_at_len = w_cnt == w_len;
    mem_we   = w_hs && !w_oob && !w_size_err && !rst;
    w_next   = aw_hs ? W_DATA : (w_hs && (axi_wlast || w_at_len)) ? W_RESP :
               (axi_bvalid && axi_bready) ? W_IDLE : w_state;
  end
  always_ff @(posedge clk) w_state <= rst ? W_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      w_size_err <= 1'b0;
      w_slv      <= 1'b0;
      w_dec      <= 1'b0;
      w_cnt      <= 8'd0;
    end else if (aw_hs) begin
      w_addr     <= {1'b0, axi_awaddr[31:2]};
      w_len      <= axi_awlen;
      w_fixed    <= axi_awburst == 2'b00;
      w_size_err <= axi_awsize != 3'b010;
      w_cnt      <= 8'd0;
      w_dec      <= 1'b0;
      w_slv      <= 1'b0;
    end else if (w_hs) begin
      w_addr <= w_fixed ? w_addr : w_addr + 31'd1;
      w_cnt  <= w_cnt + 8'd1;
      w_dec  <= w_dec || w_oob;
      w_slv  <= w_slv || (axi_wlast != w_at_len);
    end
  end
  always_ff @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (axi_wstrb[i]) mem[w_addr[MW+1:2]][8*i +: 8] <= axi_wdata[8*i +: 8];
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: table-driven single-beat vectors plus directed burst, stall, error and reset sequences
module tb_axi_mem_responder;
  logic        clk = 1'b0, rst;
  logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [7:0]  axi_awlen, axi_arlen;
  logic [2:0]  axi_awsize, axi_arsize;
  logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic [3:0]  axi_wstrb;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rlast, axi_rready;
  always #5 clk = ~clk;
  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rready(axi_rready)
  );
  int total = 0, bad = 0, gaps;
  logic [31:0] wdat [256];
  logic [31:0] rdat [256];
  logic [1:0]  rres [256];
  logic        rlst [256];
  logic [1:0]  resp;
  int          nb;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    logic [1:0]  resp;
  } vec_t;
  vec_t v [15];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic tmo(input string n);
    total++;
    bad++;
    $display("FAIL %s got=timeout exp=handshake", n);
  endtask
  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [3:0] strb, input int wlast_beat,
                          output logic [1:0] r);
    int n, i;
    axi_awaddr = addr; axi_awlen = len; axi_awburst = burst; axi_awsize = size; axi_awvalid = 1'b1;
    n = 0;
    while (!axi_awready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) tmo("aw_wait");
    @(posedge clk); #1;
    axi_awvalid = 1'b0;
    i = 0;
    while (1) begin
      axi_wdata = wdat[i]; axi_wstrb = strb; axi_wlast = i == wlast_beat; axi_wvalid = 1'b1;
      n = 0;
      while (!axi_wready && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin tmo("w_wait"); break; end
      @(posedge clk); #1;
      if (i == wlast_beat || i == int'(len)) break;
      i++;
    end
    axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1;
    n = 0;
    while (!axi_bvalid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) tmo("b_wait");
    r = axi_bresp;
    @(posedge clk); #1;
    axi_bready = 1'b0;
  endtask
  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input bit stall, output int cnt);
    int n, cyc;
    bit prev, done;
    logic [31:0] hold;
    logic hold_last;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    axi_araddr = addr; axi_arlen = len; axi_arburst = burst; axi_arsize = size; axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) tmo("ar_wait");
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    chk("rvalid_first", {31'd0, axi_rvalid}, 32'd1);
    cnt = 0; cyc = 0; prev = 0; done = 0; gaps = 0; hold = '0; hold_last = 1'b0;
    while (!done) begin
      axi_rready = stall ? pat[cyc % 4] : 1'b1;
      if (prev) begin
        chk("stall_rdata", axi_rdata, hold);
        chk("stall_rlast", {31'd0, axi_rlast}, {31'd0, hold_last});
      end
      if (!axi_rvalid) gaps++;
      if (axi_rvalid && axi_rready && cnt < 256) begin
        rdat[cnt] = axi_rdata; rres[cnt] = axi_rresp; rlst[cnt] = axi_rlast;
        done = axi_rlast;
        cnt++;
      end
      prev = axi_rvalid && !axi_rready; hold = axi_rdata; hold_last = axi_rlast;
      @(posedge clk); #1;
      cyc++;
      if (!done && cyc > 600) begin tmo("r_wait"); done = 1; end
    end
    axi_rready = 1'b0;
    chk("rvalid_after_last", {31'd0, axi_rvalid}, 32'd0);
    chk("rvalid_gaps", gaps, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
    axi_araddr = '0; axi_arlen = '0; axi_arsize = '0; axi_arburst = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    v[0]  = '{1'b1, 32'h100,  3'd2, 32'hAABBCCDD, 4'hF,    32'h0,        2'b00};
    v[1]  = '{1'b0, 32'h100,  3'd2, 32'h0,        4'h0,    32'hAABBCCDD, 2'b00};
    v[2]  = '{1'b1, 32'h100,  3'd2, 32'h11223344, 4'b0101, 32'h0,        2'b00};
    v[3]  = '{1'b0, 32'h100,  3'd2, 32'h0,        4'h0,    32'hAA22CC44, 2'b00};
    v[4]  = '{1'b1, 32'h206,  3'd2, 32'h12345678, 4'hF,    32'h0,        2'b00};
    v[5]  = '{1'b0, 32'h204,  3'd2, 32'h0,        4'h0,    32'h12345678, 2'b00};
    v[6]  = '{1'b1, 32'h400,  3'd2, 32'h5A5A5A5A, 4'hF,    32'h0,        2'b00};
    v[7]  = '{1'b1, 32'h400,  3'd1, 32'hFFFFFFFF, 4'hF,    32'h0,        2'b10};
    v[8]  = '{1'b0, 32'h400,  3'd2, 32'h0,        4'h0,    32'h5A5A5A5A, 2'b00};
    v[9]  = '{1'b0, 32'h400,  3'd1, 32'h0,        4'h0,    32'h0,        2'b10};
    v[10] = '{1'b1, 32'h4000, 3'd2, 32'h77777777, 4'hF,    32'h0,        2'b11};
    v[11] = '{1'b0, 32'h4000, 3'd2, 32'h0,        4'h0,    32'h0,        2'b11};
    v[12] = '{1'b1, 32'h3FFC, 3'd2, 32'h0BADBEEF, 4'hF,    32'h0,        2'b00};
    v[13] = '{1'b1, 32'h204,  3'd2, 32'hFFFFFFFF, 4'h0,    32'h0,        2'b00};
    v[14] = '{1'b0, 32'h204,  3'd2, 32'h0,        4'h0,    32'h12345678, 2'b00};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    chk("rst_rlast", {31'd0, axi_rlast}, 32'd0);
    chk("rst_wready", {31'd0, axi_wready}, 32'd0);
    chk("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    chk("rst_resps", {28'd0, axi_rresp, axi_bresp}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_arready", {31'd0, axi_arready}, 32'd1);
    chk("rst_awready", {31'd0, axi_awready}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      if (v[i].wr) begin
        wdat[0] = v[i].data;
        wr_burst(v[i].addr, 8'd0, 2'b01, v[i].size, v[i].strb, 0, resp);
        chk($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, v[i].resp});
      end else begin
        rd_burst(v[i].addr, 8'd0, 2'b01, v[i].size, 1'b0, nb);
        chk($sformatf("vec%0d_beats", i), nb, 32'd1);
        chk($sformatf("vec%0d_rdata", i), rdat[0], v[i].exp);
        chk($sformatf("vec%0d_rresp", i), {30'd0, rres[0]}, {30'd0, v[i].resp});
        chk($sformatf("vec%0d_rlast", i), {31'd0, rlst[0]}, 32'd1);
      end
    end
    for (int i = 0; i < 4; i++) wdat[i] = 32'h11 * (i + 1);
    wr_burst(32'h100, 8'd3, 2'b01, 3'd2, 4'hF, 3, resp);
    chk("incr4_bresp", {30'd0, resp}, 32'd0);
    rd_burst(32'h100, 8'd3, 2'b01, 3'd2, 1'b0, nb);
    chk("incr4_beats", nb, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr4_d%0d", i), rdat[i], 32'h11 * (i + 1));
      chk($sformatf("incr4_last%0d", i), {31'd0, rlst[i]}, {31'd0, i == 3});
    end
    for (int i = 0; i < 8; i++) wdat[i] = 32'hA0 + i;
    wr_burst(32'h500, 8'd7, 2'b01, 3'd2, 4'hF, 7, resp);
    chk("stall8_bresp", {30'd0, resp}, 32'd0);
    rd_burst(32'h500, 8'd7, 2'b01, 3'd2, 1'b1, nb);
    chk("stall8_beats", nb, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stall8_d%0d", i), rdat[i], 32'hA0 + i);
      chk($sformatf("stall8_last%0d", i), {31'd0, rlst[i]}, {31'd0, i == 7});
    end
    rd_burst(32'h3FFC, 8'd1, 2'b01, 3'd2, 1'b0, nb);
    chk("top_beats", nb, 32'd2);
    chk("top_d0", rdat[0], 32'h0BADBEEF);
    chk("top_r0", {30'd0, rres[0]}, 32'd0);
    chk("top_d1", rdat[1], 32'd0);
    chk("top_r1", {30'd0, rres[1]}, 32'd3);
    for (int i = 0; i < 4; i++) wdat[i] = 32'hE0 + i;
    wr_burst(32'h600, 8'd3, 2'b01, 3'd2, 4'hF, 3, resp);
    wdat[0] = 32'hD0; wdat[1] = 32'hD1;
    fork
      wr_burst(32'h600, 8'd3, 2'b01, 3'd2, 4'hF, 1, resp);
      rd_burst(32'h100, 8'd3, 2'b01, 3'd2, 1'b0, nb);
    join
    chk("early_wlast_bresp", {30'd0, resp}, 32'd2);
    chk("conc_beats", nb, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("conc_d%0d", i), rdat[i], 32'h11 * (i + 1));
    rd_burst(32'h600, 8'd3, 2'b01, 3'd2, 1'b0, nb);
    chk("early_d0", rdat[0], 32'hD0);
    chk("early_d1", rdat[1], 32'hD1);
    chk("early_d2", rdat[2], 32'hE2);
    chk("early_d3", rdat[3], 32'hE3);
    wr_burst(32'h680, 8'd1, 2'b01, 3'd2, 4'hF, 99, resp);
    chk("missing_wlast_bresp", {30'd0, resp}, 32'd2);
    wdat[0] = 32'h1; wdat[1] = 32'h2; wdat[2] = 32'h3;
    wr_burst(32'h700, 8'd2, 2'b00, 3'd2, 4'hF, 2, resp);
    chk("fixed_bresp", {30'd0, resp}, 32'd0);
    rd_burst(32'h700, 8'd2, 2'b00, 3'd2, 1'b0, nb);
    chk("fixed_beats", nb, 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("fixed_d%0d", i), rdat[i], 32'h3);
    axi_araddr = 32'h500; axi_arlen = 8'd15; axi_arsize = 3'd2; axi_arburst = 2'b01;
    axi_arvalid = 1'b1; axi_rready = 1'b1;
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_rvalid_before", {31'd0, axi_rvalid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    rst = 1'b0; axi_rready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_arready", {31'd0, axi_arready}, 32'd1);
    rd_burst(32'h500, 8'd7, 2'b01, 3'd2, 1'b0, nb);
    chk("midrst_beats", nb, 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("midrst_d%0d", i), rdat[i], 32'hA0 + i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameter: MEM_WORD_BITS, default 12, log2 of memory depth in 32-bit words (4096 words = 16 KiB).
REQ-002 Signals, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- axi_awaddr in 32, axi_awlen in 8, axi_awsize in 3, axi_awburst in 2, axi_awvalid in 1, axi_awready out 1: write address channel
- axi_wdata in 32, axi_wstrb in 4, axi_wlast in 1, axi_wvalid in 1, axi_wready out 1: write data channel
- axi_bresp out 2, axi_bvalid out 1, axi_bready in 1: write response channel
- axi_araddr in 32, axi_arlen in 8, axi_arsize in 3, axi_arburst in 2, axi_arvalid in 1, axi_arready out 1: read address channel
- axi_rdata out 32, axi_rresp out 2, axi_rvalid out 1, axi_rlast out 1, axi_rready in 1: read data channel

Function
REQ-003 AXI4 memory responder (slave) backed by a 2^MEM_WORD_BITS x 32 dual-port array; the read and write engines operate independently and concurrently.
REQ-004 Word index = addr[MEM_WORD_BITS+1:2]; addr[1:0] ignored; a beat whose addr[31:MEM_WORD_BITS+2] is nonzero is out-of-range.
REQ-005 Burst types: INCR (2'b01) adds 4 per beat; FIXED (2'b00) repeats the same address; WRAP (2'b10) and reserved (2'b11) are handled as INCR.
REQ-006 Only size 3'b010 is supported; any other ar/awsize gives SLVERR (2'b10) for the whole burst, no memory write, rdata 0.
REQ-007 Read FSM states: R_IDLE, R_BURST. arready = 1 only in R_IDLE.
REQ-008 An AR handshake in R_IDLE latches address, len, burst type and size error, clears the beat counter and moves to R_BURST.
REQ-009 First rvalid is asserted the cycle after the AR handshake; with rready held high, one beat per cycle; total beats = arlen+1 (1..256).
REQ-010 While rvalid && !rready: rdata, rresp and rlast hold stable; the next beat is not read.
REQ-011 rlast = 1 only on beat arlen. An accepted rlast beat returns the FSM to R_IDLE with rvalid = 0 the next cycle; the next AR is accepted no earlier than that cycle.
REQ-012 Per-beat rresp: OKAY 2'b00; DECERR 2'b11 with rdata 0 for out-of-range beats; SLVERR per REQ-006.
REQ-013 Write FSM states: W_IDLE, W_DATA, W_RESP. awready = 1 only in W_IDLE; wready = 1 only in W_DATA.
REQ-014 An AW handshake latches address, len, burst and size error, clears the beat counter and clears the error flags.
REQ-015 Each W handshake writes the bytes where wstrb[i] = 1 (byte i = wdata[8i+7:8i]) if the beat is in range and the size is valid; out-of-range beats are dropped and set the DECERR flag.
REQ-016 The write burst ends on the beat where wlast = 1 or the counter equals awlen, whichever comes first; then W_RESP.
REQ-017 If wlast and counter==awlen disagree on the terminating beat, SLVERR is flagged.
REQ-018 In W_RESP, bvalid = 1. bresp priority: SLVERR > DECERR > OKAY. bvalid holds until bready; handshake returns to W_IDLE.
REQ-019 Same-word read and write in the same cycle: the read returns old data; the write completes.
REQ-020 Beat counters are 8 bits; an INCR address past the top of memory becomes out-of-range, with no wrap to word 0.

Reset
REQ-021 While rst: FSMs go to R_IDLE/W_IDLE; arready = 1, awready = 1 from the first cycle after rst deasserts; rvalid, rlast, wready, bvalid = 0; rresp, bresp = 0.
REQ-022 Reset mid-burst abandons the burst, and memory contents are preserved.
REQ-023 Memory contents are not initialised by reset.

Verification
REQ-024 Write AW 0x100 len 3 INCR size 2, data 0x11..0x44, wstrb 0xF, wlast on beat 3 -> bresp OKAY; then AR 0x100 len 3 with rready = 1 -> rvalid on 4 consecutive cycles starting 1 cycle after AR, data 0x11,0x22,0x33,0x44, rlast on the 4th beat only.
REQ-025 rready toggles 1,0,0,1 during an 8-beat read -> no beat lost or duplicated, rdata stable during stalls, rlast on beat 7.
REQ-026 Word 0x40 = 0xAABBCCDD, write wstrb 4'b0101 data 0x11223344 -> read returns 0xAA22CC44.
REQ-027 AR at address 2^(MEM_WORD_BITS+2)-4, len 1 INCR -> beat 0 OKAY, beat 1 DECERR with rdata 0.
REQ-028 AW len 3 with wlast on beat 1 -> burst ends after 2 beats, bresp SLVERR; concurrent read burst unaffected.
REQ-029 rst asserted mid 16-beat read -> rvalid = 0 the next cycle, arready = 1 after release; memory unchanged.
